miner_job_scheduler: RTL and testbench

Splits one mining job across NUM_CORES fpgaminer cores by partitioning the nonce range, launches each core with a reset pulse, and tracks per-core progress until the slice is exhausted. It sits between the host/UART job interface and the core array. It collects golden-nonce reports from all cores into one round-robin valid/ready result stream.

---
 rtl/miner_sched_pkg.sv | 13 +
 rtl/miner_result_arbiter.sv | 70 +++++++
 rtl/miner_job_scheduler.sv | 170 +++++++++++++++++
 tb/tb_miner_job_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/miner_sched_pkg.sv
// miner_sched_pkg: shared widths, scheduler state encoding and the nonce-slice helper.
package miner_sched_pkg;
    localparam int NONCE_W    = 32;
    localparam int MIDSTATE_W = 256;
    localparam int DATA_W     = 96;
    localparam int SW         = NONCE_W + 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, FLUSH, DONE} state_t;

    function automatic logic [SW-1:0] slice_of(input logic [SW-1:0] span, input int unsigned log2_cores);
        return span >> log2_cores;
    endfunction
endpackage

// File: rtl/miner_result_arbiter.sv
// miner_result_arbiter: per-core pending finds merged round-robin into one valid/ready stream.
module miner_result_arbiter
    import miner_sched_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int CORE_W    = 2
) (
    input  logic                              hash_clk,
    input  logic                              reset_n,
    input  logic                              clear,
    input  logic [NUM_CORES-1:0]              set,
    input  logic [NUM_CORES-1:0][NONCE_W-1:0] set_nonce,
    input  logic                              res_ready,
    output logic                              res_valid,
    output logic [NONCE_W-1:0]                res_nonce,
    output logic [CORE_W-1:0]                 res_core,
    output logic [NUM_CORES-1:0]              pending
);
    logic [NUM_CORES-1:0][NONCE_W-1:0] nonce;
    logic [NUM_CORES-1:0] avail;
    logic [CORE_W-1:0] ptr, pick, j;
    logic found, take;

    assign take = res_valid && res_ready;

    // ptr is the first index considered, i.e. one past the last grant
    always_comb begin
        avail = pending;
        found = 1'b0;
        pick = '0;
        j = '0;
        if (take) avail[res_core] = 1'b0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            j = CORE_W'((int'(ptr) + k) % NUM_CORES);
            if (avail[j]) begin
                found = 1'b1;
                pick = j;
            end
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            nonce <= '0;
            res_valid <= 1'b0;
            res_nonce <= '0;
            res_core <= '0;
            ptr <= '0;
        end else if (clear) begin
            pending <= '0;
            res_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (set[i]) begin
                    pending[i] <= 1'b1;
                    nonce[i] <= set_nonce[i];
                end else if (take && res_core == CORE_W'(i)) pending[i] <= 1'b0;
            end
            if (!res_valid || res_ready) begin
                res_valid <= found;
                if (found) begin
                    res_core <= pick;
                    res_nonce <= nonce[pick];
                    ptr <= CORE_W'((int'(pick) + 1) % NUM_CORES);
                end
            end
        end
    end
endmodule

// File: rtl/miner_job_scheduler.sv
// miner_job_scheduler: splits a job's nonce range across NUM_CORES cores and tracks them to completion.
// Define MINER_SCHED_RESUME_EN to relaunch a core on the rest of its slice once its result is taken.
module miner_job_scheduler
    import miner_sched_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int LOOP_LOG2    = 5,
    parameter int DRAIN_NONCES = 4,
    parameter int CORE_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                         hash_clk,
    input  logic                         reset_n,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [MIDSTATE_W-1:0]        job_midstate,
    input  logic [DATA_W-1:0]            job_data,
    input  logic [NONCE_W-1:0]           job_nonce_min,
    input  logic [NONCE_W-1:0]           job_nonce_max,
    input  logic                         abort,
    output logic [MIDSTATE_W-1:0]        core_midstate,
    output logic [DATA_W-1:0]            core_data,
    output logic [NONCE_W*NUM_CORES-1:0] core_nonce_min,
    output logic [NONCE_W*NUM_CORES-1:0] core_nonce_max,
    output logic [NUM_CORES-1:0]         core_reset,
    input  logic [NONCE_W*NUM_CORES-1:0] core_golden_nonce,
    input  logic [NUM_CORES-1:0]         core_new_golden,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [NONCE_W-1:0]           res_nonce,
    output logic [CORE_W-1:0]            res_core,
    output logic                         busy,
    output logic                         job_done
);
    localparam int LOG_N = $clog2(NUM_CORES);

    state_t state, state_nx;
    logic [NUM_CORES-1:0][NONCE_W-1:0] cmin, cmax, gn_q;
    logic [SW-1:0] rem [NUM_CORES];
    logic [2:0] hold [NUM_CORES];
    logic [SW-1:0] span, slice, span_in, l_rem;
    logic [NONCE_W-1:0] nmax, base, l_min, l_max;
    logic [CORE_W-1:0] idx;
    logic [LOOP_LOG2-1:0] tick_cnt;
    logic [NUM_CORES-1:0] active, g1, g2, find, hit, pending;
    logic stop, last, launch, resume, run, tick, accept;

    assign core_nonce_min = cmin;
    assign core_nonce_max = cmax;
    assign job_ready = state == IDLE;
    assign busy = state != IDLE;
    assign stop = abort && busy;
    assign job_done = state == DONE && !abort;
    assign accept = job_valid && job_ready;
    assign span_in = (job_nonce_max < job_nonce_min) ? '0 : {1'b0, job_nonce_max} - {1'b0, job_nonce_min} + SW'(1);
    assign last = idx == CORE_W'(NUM_CORES - 1);
    // a zero slice means fewer nonces than cores: core i takes the single nonce min+i
    assign launch = state == LAUNCH && !abort && (slice != '0 || SW'(idx) < span);
    assign l_min = (slice == '0) ? base + NONCE_W'(idx) : base;
    assign l_max = last ? nmax : (slice == '0) ? l_min : NONCE_W'(SW'(base) + slice - SW'(1));
    assign l_rem = {1'b0, l_max} - {1'b0, l_min} + SW'(DRAIN_NONCES + 1);
    assign run = state == RUN || state == FLUSH;
    assign tick = run && &tick_cnt;

`ifdef MINER_SCHED_RESUME_EN
    assign resume = res_valid && res_ready && busy && !abort && ({1'b0, res_nonce} + SW'(1) <= {1'b0, cmax[res_core]});
`else
    assign resume = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            find[i] = g1[i] && !g2[i] && active[i] && hold[i] == 3'd0;
            hit[i] = find[i] && gn_q[i] >= cmin[i] && gn_q[i] <= cmax[i];
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (span_in == '0) ? DONE : LAUNCH;
            LAUNCH:  if (last) state_nx = RUN;
            RUN:     if (active == '0) state_nx = FLUSH;
            FLUSH:   state_nx = (|active) ? RUN : (pending == '0) ? DONE : FLUSH;
            default: state_nx = IDLE;
        endcase
        if (stop) state_nx = IDLE;
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            core_midstate <= '0;
            core_data <= '0;
            nmax <= '0;
            base <= '0;
            span <= '0;
            slice <= '0;
            idx <= '0;
            tick_cnt <= '0;
            cmin <= '0;
            cmax <= '0;
            gn_q <= '0;
            g1 <= '0;
            g2 <= '0;
            core_reset <= '0;
            active <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                rem[i] <= '0;
                hold[i] <= '0;
            end
        end else begin
            g1 <= core_new_golden;
            g2 <= g1;
            gn_q <= core_golden_nonce;
            tick_cnt <= run ? tick_cnt + LOOP_LOG2'(1) : '0;
            if (accept) begin
                core_midstate <= job_midstate;
                core_data <= job_data;
                nmax <= job_nonce_max;
                base <= job_nonce_min;
                span <= span_in;
                slice <= slice_of(span_in, LOG_N);
                idx <= '0;
                cmin <= '0;
                cmax <= '0;
            end
            if (state == LAUNCH) begin
                idx <= idx + CORE_W'(1);
                base <= base + NONCE_W'(slice);
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                core_reset[i] <= 1'b0;
                if (hold[i] != 3'd0) hold[i] <= hold[i] - 3'd1;
                if (stop) active[i] <= 1'b0;
                else if (launch && idx == CORE_W'(i)) begin
                    cmin[i] <= l_min;
                    cmax[i] <= l_max;
                    rem[i] <= l_rem;
                    active[i] <= 1'b1;
                    core_reset[i] <= 1'b1;
                    hold[i] <= 3'd4;
                end else if (resume && res_core == CORE_W'(i)) begin
                    cmin[i] <= res_nonce + NONCE_W'(1);
                    rem[i] <= {1'b0, cmax[i]} - {1'b0, res_nonce} + SW'(DRAIN_NONCES);
                    active[i] <= 1'b1;
                    core_reset[i] <= 1'b1;
                    hold[i] <= 3'd4;
                end else if (active[i] && (find[i] || rem[i] == '0)) active[i] <= 1'b0;
                else if (active[i] && tick) rem[i] <= rem[i] - SW'(1);
            end
        end
    end

    miner_result_arbiter #(.NUM_CORES(NUM_CORES), .CORE_W(CORE_W)) u_arb (
        .hash_clk(hash_clk),
        .reset_n(reset_n),
        .clear(stop),
        .set(hit),
        .set_nonce(gn_q),
        .res_ready(res_ready),
        .res_valid(res_valid),
        .res_nonce(res_nonce),
        .res_core(res_core),
        .pending(pending)
    );
endmodule

// File: tb/tb_miner_job_scheduler.sv
// tb_miner_job_scheduler: scoreboard bench for a 4-core scheduler; define MINER_SCHED_RESUME_EN to cover relaunch.
module tb_miner_job_scheduler;
    localparam int N = 4;

    logic hash_clk = 0, reset_n = 0;
    logic job_valid = 0, abort = 0, res_ready = 1;
    logic [255:0] job_midstate = '0;
    logic [95:0] job_data = '0;
    logic [31:0] job_nonce_min = '0, job_nonce_max = '0;
    logic [N-1:0][31:0] gn = '0;
    logic [N-1:0] core_new_golden = '0;
    logic job_ready, busy, job_done, res_valid;
    logic [255:0] core_midstate;
    logic [95:0] core_data;
    logic [127:0] core_nonce_min, core_nonce_max;
    logic [N-1:0] core_reset;
    logic [31:0] res_nonce;
    logic [1:0] res_core;

    int total = 0, bad = 0, done_cnt = 0, n;
    logic [33:0] exp_q[$];
    logic stall = 0;
    logic [34:0] held = '0;

    miner_job_scheduler #(.NUM_CORES(N), .LOOP_LOG2(2), .DRAIN_NONCES(4)) dut (
        .hash_clk(hash_clk),
        .reset_n(reset_n),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_midstate(job_midstate),
        .job_data(job_data),
        .job_nonce_min(job_nonce_min),
        .job_nonce_max(job_nonce_max),
        .abort(abort),
        .core_midstate(core_midstate),
        .core_data(core_data),
        .core_nonce_min(core_nonce_min),
        .core_nonce_max(core_nonce_max),
        .core_reset(core_reset),
        .core_golden_nonce(gn),
        .core_new_golden(core_new_golden),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_nonce(res_nonce),
        .res_core(res_core),
        .busy(busy),
        .job_done(job_done)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] lo, input logic [31:0] hi);
        chk("ready_before_job", job_ready, 1'b1);
        job_nonce_min = lo;
        job_nonce_max = hi;
        job_midstate = {8{$urandom}};
        job_data = {3{$urandom}};
        job_valid = 1;
        tick();
        job_valid = 0;
    endtask

    task automatic wait_done(input string tag);
        n = 0;
        while (!job_done && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, job_done, 1'b1);
    endtask

    // handshakes are taken at the following rising edge, so the falling edge sees them settled
    always @(negedge hash_clk) begin
        if (reset_n) begin
            if (stall) chk("res_hold", {res_valid, res_core, res_nonce}, held);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) chk("res_unexpected", res_valid, 1'b0);
                else chk("res", {res_core, res_nonce}, exp_q.pop_front());
            end
            if (job_done) done_cnt <= done_cnt + 1;
            stall <= res_valid && !res_ready;
            held <= {res_valid, res_core, res_nonce};
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_ready", job_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_reset", core_reset, 4'h0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_done", job_done, 1'b0);
        chk("rst_min", core_nonce_min, 128'h0);
        chk("rst_max", core_nonce_max, 128'h0);
        reset_n = 1;
        tick();

        start_job(32'h100, 32'h1FF);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("launch_pulse", core_reset, (k < 4) ? 4'(1 << k) : 4'h0);
        end
        chk("slice_min", core_nonce_min, 128'h000001C0_00000180_00000140_00000100);
        chk("slice_max", core_nonce_max, 128'h000001FF_000001BF_0000017F_0000013F);
        chk("payload_data", core_data, job_data);
        chk("payload_mid", core_midstate[127:0], job_midstate[127:0]);
        chk("busy_run", busy, 1'b1);
        repeat (6) tick();
        res_ready = 0;
        gn[0] = 32'h110;
        gn[3] = 32'h1F0;
        core_new_golden = 4'b1001;
        exp_q.push_back({2'd0, 32'h110});
        exp_q.push_back({2'd3, 32'h1F0});
        tick();
        chk("lat_e", res_valid, 1'b0);
        tick();
        chk("lat_e1", res_valid, 1'b0);
        tick();
        chk("lat_e2", res_valid, 1'b1);
        chk("rr_first", res_core, 2'd0);
        repeat (3) tick();
        res_ready = 1;
        repeat (4) tick();
        gn[2] = 32'h185;
        core_new_golden[2] = 1;
        exp_q.push_back({2'd2, 32'h185});
        wait_done("job1_done");
        repeat (3) tick();
        chk("job1_done_cnt", done_cnt, 1);
        chk("job1_sb_empty", exp_q.size(), 0);
        core_new_golden = '0;
        tick();

        start_job(32'h10, 32'h11);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("small_pulse", core_reset, (k < 2) ? 4'(1 << k) : 4'h0);
        end
        chk("small_min", core_nonce_min, 128'h00000000_00000000_00000011_00000010);
        chk("small_max", core_nonce_max, 128'h00000000_00000000_00000011_00000010);
        wait_done("small_done");
        repeat (3) tick();
        chk("small_done_cnt", done_cnt, 2);

        start_job(32'h5, 32'h4);
        chk("empty_done", job_done, 1'b1);
        chk("empty_no_rst", core_reset, 4'h0);
        tick();
        chk("empty_idle", job_ready, 1'b1);
        chk("empty_no_rst2", core_reset, 4'h0);
        repeat (2) tick();
        chk("empty_done_cnt", done_cnt, 3);

        start_job(32'h0, 32'hFF);
        repeat (11) tick();
        chk("oor_slice1", core_nonce_min[63:32], 32'h40);
        gn[1] = 32'h90;
        core_new_golden[1] = 1;
        repeat (6) tick();
        chk("oor_no_res", res_valid, 1'b0);
        chk("oor_busy", busy, 1'b1);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", job_ready, 1'b1);
        chk("abort_res", res_valid, 1'b0);
        repeat (20) tick();
        chk("abort_no_done", done_cnt, 3);
        core_new_golden = '0;
        tick();

`ifdef MINER_SCHED_RESUME_EN
        start_job(32'h100, 32'h1FF);
        repeat (11) tick();
        gn[0] = 32'h120;
        core_new_golden[0] = 1;
        exp_q.push_back({2'd0, 32'h120});
        n = 0;
        while (!core_reset[0] && n < 50) begin
            tick();
            n++;
        end
        chk("resume_rst", core_reset[0], 1'b1);
        chk("resume_min", core_nonce_min[31:0], 32'h121);
        chk("resume_max", core_nonce_max[31:0], 32'h13F);
        abort = 1;
        tick();
        abort = 0;
        core_new_golden = '0;
        tick();
`endif

        chk("sb_final", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
